// File: rtl/reg_file_pkg.sv
// Shared defaults and read-mode encodings for the parameterised register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 2;

  // Read-port modes selected by READ_REG
  localparam int READ_MODE_COMB = 0;
  localparam int READ_MODE_REG  = 1;

  // Number of registers addressed by an index of the given width
  function automatic int reg_count(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/decoder_param.sv
// ADDR_W-to-2**ADDR_W one-hot decoder with enable; all outputs low when en=0.
module decoder_param #(
  parameter int ADDR_W = 2
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] sel
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_sel
      assign sel[gi] = en && (addr == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two read ports, synchronous
// clear, optional hardwired-zero register 0 and optional registered reads.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int READ_REG = READ_MODE_COMB,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid
);

  localparam int NREGS = reg_count(ADDR_W);

  logic [NREGS-1:0][DATA_W-1:0] regs_reg;
  logic [NREGS-1:0][DATA_W-1:0] regs_next;
  logic [NREGS-1:0]             wr_sel;
  logic                         wr_blocked;
  logic                         dec_en;

  // Writes to register 0 are dropped when it is hardwired to zero; since
  // reset and clr also zero it, register 0 then always reads back as 0.
  assign wr_blocked = (ZERO_REG != 0) && (wr_addr == '0);
  assign dec_en     = wr_en && !wr_blocked;

  decoder_param #(
    .ADDR_W(ADDR_W)
  ) u_dec (
    .en  (dec_en),
    .addr(wr_addr),
    .sel (wr_sel)
  );

  // regs_next is the post-edge content of every register; the registered
  // read path samples it directly, which gives write-first forwarding and
  // clear-returns-zero behaviour for free.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_next
      assign regs_next[gi] = clr        ? '0      :
                             wr_sel[gi] ? wr_data : regs_reg[gi];
    end
  endgenerate

  // Register storage: clear has priority over the decoded write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_reg <= '0;
    end else begin
      regs_reg <= regs_next;
    end
  end

  generate
    if (READ_REG == READ_MODE_REG) begin : g_rd_reg
      logic [DATA_W-1:0] rd_a_reg;
      logic [DATA_W-1:0] rd_b_reg;
      logic              rd_valid_reg;

      // Capture post-edge contents on a request, hold otherwise; valid is a
      // one-cycle echo of rd_req and is dropped by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_a_reg     <= '0;
          rd_b_reg     <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_req;
          if (rd_req) begin
            rd_a_reg <= regs_next[rd_addr_a];
            rd_b_reg <= regs_next[rd_addr_b];
          end
        end
      end

      assign rd_data_a = rd_a_reg;
      assign rd_data_b = rd_b_reg;
      assign rd_valid  = rd_valid_reg;
    end else begin : g_rd_comb
      // rd_req has no meaning for combinational reads
      logic unused_rd_req;
      assign unused_rd_req = rd_req;

      assign rd_data_a = regs_reg[rd_addr_a];
      assign rd_data_b = regs_reg[rd_addr_b];
      assign rd_valid  = rst_n;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: combinational, registered, zero-reg and
// wide instances driven from one stimulus sequence.
module tb_reg_file_param;

  int test_cnt = 0;
  int fail_cnt = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr;
  logic        rd_req;
  logic [1:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;

  logic [15:0] c_rd_data_a, c_rd_data_b;
  logic        c_rd_valid;
  logic [15:0] r_rd_data_a, r_rd_data_b;
  logic        r_rd_valid;
  logic [15:0] z_rd_data_a, z_rd_data_b;
  logic        z_rd_valid;

  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_clr;
  logic        w_rd_req;
  logic [2:0]  w_rd_addr_a;
  logic [2:0]  w_rd_addr_b;
  logic [31:0] w_rd_data_a, w_rd_data_b;
  logic        w_rd_valid;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(16), .ADDR_W(2), .READ_REG(0), .ZERO_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(c_rd_data_a), .rd_data_b(c_rd_data_b), .rd_valid(c_rd_valid)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(2), .READ_REG(1), .ZERO_REG(0)) u_regd (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(r_rd_data_a), .rd_data_b(r_rd_data_b), .rd_valid(r_rd_valid)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(2), .READ_REG(0), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b), .rd_valid(z_rd_valid)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(3), .READ_REG(0), .ZERO_REG(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .clr(w_clr), .rd_req(w_rd_req), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
    .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b), .rd_valid(w_rd_valid)
  );

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
    $display("[TB] write reg%0d = %h", addr, data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_clr = 1'b0; w_rd_req = 1'b0;
    w_rd_addr_a = '0; w_rd_addr_b = '0;
    #1;
    test_cnt++; if (c_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_c_valid: got %b want 0", c_rd_valid); end
    test_cnt++; if (r_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_r_valid: got %b want 0", r_rd_valid); end
    test_cnt++; if (r_rd_data_a !== 16'h0) begin fail_cnt++; $display("FAIL rst_r_data_a: got %h want 0000", r_rd_data_a); end
    tick(); tick();
    test_cnt++; if (c_rd_data_a !== 16'h0) begin fail_cnt++; $display("FAIL rst_c_data_a: got %h want 0000", c_rd_data_a); end
    rst_n = 1'b1;
    #1;
    test_cnt++; if (c_rd_valid !== 1'b1) begin fail_cnt++; $display("FAIL rel_c_valid: got %b want 1", c_rd_valid); end
    test_cnt++; if (r_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL rel_r_valid: got %b want 0", r_rd_valid); end
    $display("[TB] reset sequence done");
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1234; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    #1;
    test_cnt++; if (c_rd_data_a !== 16'h0000) begin fail_cnt++; $display("FAIL pre_edge_a: got %h want 0000", c_rd_data_a); end
    tick();
    wr_addr = 2'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    #1;
    test_cnt++; if (c_rd_data_a !== 16'h1234) begin fail_cnt++; $display("FAIL wr_rd_a: got %h want 1234", c_rd_data_a); end
    test_cnt++; if (c_rd_data_b !== 16'hBEEF) begin fail_cnt++; $display("FAIL wr_rd_b: got %h want beef", c_rd_data_b); end
    test_cnt++; if (r_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL no_req_valid: got %b want 0", r_rd_valid); end
    rd_addr_a = 2'd1; rd_addr_b = 2'd0;
    #1;
    test_cnt++; if (c_rd_data_a !== 16'h0000) begin fail_cnt++; $display("FAIL onehot_r1: got %h want 0000", c_rd_data_a); end
    test_cnt++; if (c_rd_data_b !== 16'h0000) begin fail_cnt++; $display("FAIL onehot_r0: got %h want 0000", c_rd_data_b); end
    $display("[TB] write/read reg2=1234 reg3=beef checked");
  endtask

  task automatic test_hold();
    wr_en = 1'b0; wr_addr = 2'd2; wr_data = 16'hFFFF; rd_addr_a = 2'd2;
    tick();
    test_cnt++; if (c_rd_data_a !== 16'h1234) begin fail_cnt++; $display("FAIL hold_r2: got %h want 1234", c_rd_data_a); end
    $display("[TB] wr_en=0 hold checked");
  endtask

  task automatic test_forward();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h00FF; rd_req = 1'b1;
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    tick();
    wr_en = 1'b0; rd_req = 1'b0; rd_addr_a = 2'd2;
    test_cnt++; if (r_rd_data_a !== 16'h00FF) begin fail_cnt++; $display("FAIL fwd_a: got %h want 00ff", r_rd_data_a); end
    test_cnt++; if (r_rd_data_b !== 16'hBEEF) begin fail_cnt++; $display("FAIL fwd_b: got %h want beef", r_rd_data_b); end
    test_cnt++; if (r_rd_valid !== 1'b1) begin fail_cnt++; $display("FAIL fwd_valid: got %b want 1", r_rd_valid); end
    tick();
    test_cnt++; if (r_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL fwd_valid_drop: got %b want 0", r_rd_valid); end
    test_cnt++; if (r_rd_data_a !== 16'h00FF) begin fail_cnt++; $display("FAIL fwd_hold_a: got %h want 00ff", r_rd_data_a); end
    $display("[TB] registered write-first forward checked");
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    tick();
    test_cnt++; if (r_rd_valid !== 1'b1 || r_rd_data_a !== 16'h1234 || r_rd_data_b !== 16'hBEEF) begin
      fail_cnt++; $display("FAIL b2b_1: got v=%b a=%h b=%h want v=1 a=1234 b=beef", r_rd_valid, r_rd_data_a, r_rd_data_b); end
    rd_addr_a = 2'd3; rd_addr_b = 2'd1;
    tick();
    test_cnt++; if (r_rd_valid !== 1'b1 || r_rd_data_a !== 16'hBEEF || r_rd_data_b !== 16'h00FF) begin
      fail_cnt++; $display("FAIL b2b_2: got v=%b a=%h b=%h want v=1 a=beef b=00ff", r_rd_valid, r_rd_data_a, r_rd_data_b); end
    rd_req = 1'b0;
    tick();
    test_cnt++; if (r_rd_valid !== 1'b0) begin fail_cnt++; $display("FAIL b2b_end: got %b want 0", r_rd_valid); end
    $display("[TB] back-to-back reads checked");
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hAAAA; rd_req = 1'b1; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    test_cnt++; if (r_rd_data_a !== 16'hAAAA || r_rd_data_b !== 16'hAAAA) begin
      fail_cnt++; $display("FAIL same_addr_fwd: got a=%h b=%h want aaaa", r_rd_data_a, r_rd_data_b); end
    test_cnt++; if (c_rd_data_a !== 16'hAAAA) begin fail_cnt++; $display("FAIL c_reg0: got %h want aaaa", c_rd_data_a); end
    test_cnt++; if (z_rd_data_a !== 16'h0000) begin fail_cnt++; $display("FAIL z_reg0: got %h want 0000", z_rd_data_a); end
    do_write(2'd1, 16'h5555);
    rd_addr_b = 2'd1;
    #1;
    test_cnt++; if (z_rd_data_a !== 16'h0000) begin fail_cnt++; $display("FAIL z_reg0_after: got %h want 0000", z_rd_data_a); end
    test_cnt++; if (z_rd_data_b !== 16'h5555) begin fail_cnt++; $display("FAIL z_reg1: got %h want 5555", z_rd_data_b); end
    $display("[TB] zero register checked");
  endtask

  task automatic test_clr();
    do_write(2'd0, 16'h1111);
    do_write(2'd1, 16'h2222);
    do_write(2'd2, 16'h3333);
    do_write(2'd3, 16'h4444);
    rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    #1;
    test_cnt++; if (c_rd_data_a !== 16'h2222 || c_rd_data_b !== 16'h3333) begin
      fail_cnt++; $display("FAIL fill: got a=%h b=%h want 2222 3333", c_rd_data_a, c_rd_data_b); end
    clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h9999; rd_req = 1'b1;
    tick();
    clr = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    test_cnt++; if (r_rd_valid !== 1'b1 || r_rd_data_a !== 16'h0 || r_rd_data_b !== 16'h0) begin
      fail_cnt++; $display("FAIL clr_rd: got v=%b a=%h b=%h want v=1 0000 0000", r_rd_valid, r_rd_data_a, r_rd_data_b); end
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
      #1;
      test_cnt++; if (c_rd_data_a !== 16'h0 || c_rd_data_b !== 16'h0 || z_rd_data_a !== 16'h0) begin
        fail_cnt++; $display("FAIL clr_r%0d: got c_a=%h c_b=%h z_a=%h want 0000", i, c_rd_data_a, c_rd_data_b, z_rd_data_a); end
    end
    $display("[TB] clear with simultaneous write checked");
  endtask

  task automatic test_reset_mid();
    do_write(2'd2, 16'h7777);
    rd_req = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd2;
    tick();
    rd_req = 1'b0;
    test_cnt++; if (r_rd_valid !== 1'b1 || r_rd_data_a !== 16'h7777) begin
      fail_cnt++; $display("FAIL pre_rst_rd: got v=%b a=%h want v=1 7777", r_rd_valid, r_rd_data_a); end
    #2;
    rst_n = 1'b0;
    #1;
    test_cnt++; if (r_rd_valid !== 1'b0 || r_rd_data_a !== 16'h0 || r_rd_data_b !== 16'h0) begin
      fail_cnt++; $display("FAIL async_rst: got v=%b a=%h b=%h want 0", r_rd_valid, r_rd_data_a, r_rd_data_b); end
    test_cnt++; if (c_rd_valid !== 1'b0 || c_rd_data_a !== 16'h0) begin
      fail_cnt++; $display("FAIL async_rst_c: got v=%b a=%h want 0", c_rd_valid, c_rd_data_a); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    test_cnt++; if (r_rd_valid !== 1'b0 || r_rd_data_a !== 16'h0) begin
      fail_cnt++; $display("FAIL post_rst_idle: got v=%b a=%h want 0", r_rd_valid, r_rd_data_a); end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    test_cnt++; if (r_rd_valid !== 1'b1 || r_rd_data_a !== 16'h0) begin
      fail_cnt++; $display("FAIL post_rst_req: got v=%b a=%h want v=1 0000", r_rd_valid, r_rd_data_a); end
    $display("[TB] reset during registered read checked");
  endtask

  task automatic test_wide();
    for (int i = 0; i < 8; i++) begin
      w_wr_en = 1'b1; w_wr_addr = 3'(i); w_wr_data = 32'(i) * 32'h01010101;
      tick();
    end
    w_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_rd_addr_a = 3'(i); w_rd_addr_b = 3'(7 - i);
      #1;
      test_cnt++; if (w_rd_data_a !== 32'(i) * 32'h01010101 || w_rd_data_b !== 32'(7 - i) * 32'h01010101) begin
        fail_cnt++; $display("FAIL wide_r%0d: got a=%h b=%h want a=%h b=%h", i, w_rd_data_a, w_rd_data_b,
                             32'(i) * 32'h01010101, 32'(7 - i) * 32'h01010101); end
    end
    test_cnt++; if (w_rd_valid !== 1'b1) begin fail_cnt++; $display("FAIL wide_valid: got %b want 1", w_rd_valid); end
    $display("[TB] wide sweep ADDR_W=3 DATA_W=32 checked");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_forward();
    test_back_to_back();
    test_zero_reg();
    test_clr();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
